// File: rtl/secuenciador_rtc.sv
// -----------------------------------------------------------------------------
// secuenciador_rtc
//
// Transaction sequencer placed in front of the RTC bus-cycle generator
// (control_salida). A read request issues the "transfer to registers"
// command followed by six register reads, assembling a coherent 48-bit
// time/date word. A write request latches hora_in and issues six register
// writes followed by the "transfer to clock" command. Each transaction is
// started with iniciar and finished when the bus stage answers with fin_trans.
// A transaction that never finishes aborts the sweep with an error pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   leer       read-sweep request (sampled only while idle)
//   escribir   write-sweep request (sampled only while idle, wins over leer)
//   hora_in    bytes to write: [7:0] seg .. [47:40] year
//   fin_trans  end-of-transaction from control_salida (the bus stage calls it
//              "final", which is a reserved word in SystemVerilog)
//   dato_bus   read data, stable while fin_trans is high
//   iniciar    transaction enable to control_salida
//   escribe    1 = write transaction, 0 = read transaction
//   direccion  transaction address
//   dato       write data
//   hora_out   last complete read, same byte order as hora_in
//   ocupado    high while a sweep is in progress
//   listo      one-cycle pulse on successful completion
//   error      one-cycle pulse on timeout abort
// -----------------------------------------------------------------------------
module secuenciador_rtc #(
   parameter logic [7:0] BASE_REG      = 8'h21,
   parameter logic [7:0] CMD_LECTURA   = 8'hF0,
   parameter logic [7:0] CMD_ESCRITURA = 8'hF1,
   parameter logic [7:0] TIMEOUT       = 8'd60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        leer,
   input  logic        escribir,
   input  logic [47:0] hora_in,
   input  logic        fin_trans,
   input  logic [7:0]  dato_bus,
   output logic        iniciar,
   output logic        escribe,
   output logic [7:0]  direccion,
   output logic [7:0]  dato,
   output logic [47:0] hora_out,
   output logic        ocupado,
   output logic        listo,
   output logic        error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ESPERA = 2'd1,
      LIBERA = 2'd2,
      FIN    = 2'd3
   } estado_t;

   estado_t     estado_q, estado_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [47:0] sombra_q, sombra_d;
   logic        modo_esc_q, modo_esc_d;
   logic        iniciar_q, iniciar_d;
   logic        escribe_q, escribe_d;
   logic [7:0]  direccion_q, direccion_d;
   logic [7:0]  dato_q, dato_d;
   logic [47:0] hora_out_q, hora_out_d;
   logic        ocupado_q, ocupado_d;
   logic        listo_q, listo_d;
   logic        error_q, error_d;

   // Byte n (0..5) of a 48-bit time word.
   function automatic logic [7:0] byte_de(input logic [47:0] palabra, input logic [2:0] n);
      logic [7:0] b;
      case (n)
         3'd0:    b = palabra[7:0];
         3'd1:    b = palabra[15:8];
         3'd2:    b = palabra[23:16];
         3'd3:    b = palabra[31:24];
         3'd4:    b = palabra[39:32];
         3'd5:    b = palabra[47:40];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Replace byte n (0..5) of a 48-bit time word.
   function automatic logic [47:0] pone_byte(input logic [47:0] palabra, input logic [2:0] n,
                                             input logic [7:0] b);
      logic [47:0] r;
      r = palabra;
      case (n)
         3'd0:    r[7:0]   = b;
         3'd1:    r[15:8]  = b;
         3'd2:    r[23:16] = b;
         3'd3:    r[31:24] = b;
         3'd4:    r[39:32] = b;
         3'd5:    r[47:40] = b;
         default: r = palabra;
      endcase
      return r;
   endfunction

   // {escribe, direccion, dato} for transaction n of a read or write sweep.
   function automatic logic [16:0] transaccion(input logic modo_esc, input logic [2:0] n,
                                               input logic [47:0] sombra);
      logic [16:0] t;
      if (modo_esc) begin
         if (n == 3'd6) t = {1'b1, CMD_ESCRITURA, 8'h00};
         else           t = {1'b1, BASE_REG + {5'd0, n}, byte_de(sombra, n)};
      end else begin
         // Read sweep: command first, so register k sits at transaction k+1.
         if (n == 3'd0) t = {1'b1, CMD_LECTURA, 8'h00};
         else           t = {1'b0, BASE_REG + {5'd0, n} - 8'd1, 8'h00};
      end
      return t;
   endfunction

   // Next-state and next-output computation for the sweep sequencer.
   always_comb begin
      estado_d    = estado_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      sombra_d    = sombra_q;
      modo_esc_d  = modo_esc_q;
      iniciar_d   = iniciar_q;
      escribe_d   = escribe_q;
      direccion_d = direccion_q;
      dato_d      = dato_q;
      hora_out_d  = hora_out_q;
      ocupado_d   = ocupado_q;
      listo_d     = 1'b0;
      error_d     = 1'b0;

      case (estado_q)
         IDLE: begin
            if (escribir || leer) begin
               modo_esc_d = escribir;
               if (escribir) sombra_d = hora_in;
               else          sombra_d = sombra_q;
               idx_d = 3'd0;
               cnt_d = 8'd0;
               {escribe_d, direccion_d, dato_d} = transaccion(escribir, 3'd0, hora_in);
               iniciar_d = 1'b1;
               ocupado_d = 1'b1;
               estado_d  = ESPERA;
            end else begin
               estado_d = IDLE;
            end
         end
         ESPERA: begin
            if (fin_trans) begin
               if (!modo_esc_q && (idx_q != 3'd0)) sombra_d = pone_byte(sombra_q, idx_q - 3'd1, dato_bus);
               else                                sombra_d = sombra_q;
               iniciar_d = 1'b0;
               estado_d  = LIBERA;
            end else if (cnt_q >= (TIMEOUT - 8'd1)) begin
               // This edge is the TIMEOUT-th one spent waiting: abort the sweep.
               iniciar_d = 1'b0;
               ocupado_d = 1'b0;
               error_d   = 1'b1;
               estado_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         LIBERA: begin
            if (idx_q < 3'd6) begin
               idx_d = idx_q + 3'd1;
               {escribe_d, direccion_d, dato_d} = transaccion(modo_esc_q, idx_q + 3'd1, sombra_q);
               iniciar_d = 1'b1;
               cnt_d     = 8'd0;
               estado_d  = ESPERA;
            end else begin
               estado_d = FIN;
            end
         end
         FIN: begin
            listo_d   = 1'b1;
            ocupado_d = 1'b0;
            // All six bytes are published on the same edge so hora_out never mixes sweeps.
            if (!modo_esc_q) hora_out_d = sombra_q;
            else             hora_out_d = hora_out_q;
            estado_d = IDLE;
         end
         default: begin
            estado_d  = IDLE;
            iniciar_d = 1'b0;
            ocupado_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q    <= IDLE;
         idx_q       <= 3'd0;
         cnt_q       <= 8'd0;
         sombra_q    <= 48'h0;
         modo_esc_q  <= 1'b0;
         iniciar_q   <= 1'b0;
         escribe_q   <= 1'b0;
         direccion_q <= 8'h00;
         dato_q      <= 8'h00;
         hora_out_q  <= 48'h0;
         ocupado_q   <= 1'b0;
         listo_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         sombra_q    <= sombra_d;
         modo_esc_q  <= modo_esc_d;
         iniciar_q   <= iniciar_d;
         escribe_q   <= escribe_d;
         direccion_q <= direccion_d;
         dato_q      <= dato_d;
         hora_out_q  <= hora_out_d;
         ocupado_q   <= ocupado_d;
         listo_q     <= listo_d;
         error_q     <= error_d;
      end
   end

   assign iniciar   = iniciar_q;
   assign escribe   = escribe_q;
   assign direccion = direccion_q;
   assign dato      = dato_q;
   assign hora_out  = hora_out_q;
   assign ocupado   = ocupado_q;
   assign listo     = listo_q;
   assign error     = error_q;

endmodule

// File: tb/tb_secuenciador_rtc.sv
// -----------------------------------------------------------------------------
// Bench for secuenciador_rtc: a behavioural control_salida answers each
// transaction lat_f cycles after iniciar rises with dato_bus = base + address.
// Expected transactions go into a queue when a sweep is requested and are
// popped as the DUT starts each transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_secuenciador_rtc;

   logic        clk = 1'b0;
   logic        reset;
   logic        leer;
   logic        escribir;
   logic [47:0] hora_in;
   logic        fin_trans;
   logic [7:0]  dato_bus;
   logic        iniciar;
   logic        escribe;
   logic [7:0]  direccion;
   logic [7:0]  dato;
   logic [47:0] hora_out;
   logic        ocupado;
   logic        listo;
   logic        error;

   always #5 clk = ~clk;

   secuenciador_rtc dut (
      .clk       (clk),
      .reset     (reset),
      .leer      (leer),
      .escribir  (escribir),
      .hora_in   (hora_in),
      .fin_trans (fin_trans),
      .dato_bus  (dato_bus),
      .iniciar   (iniciar),
      .escribe   (escribe),
      .direccion (direccion),
      .dato      (dato),
      .hora_out  (hora_out),
      .ocupado   (ocupado),
      .listo     (listo),
      .error     (error)
   );

   typedef struct {
      logic       escribe;
      logic [7:0] dir;
      logic [7:0] dato;
      logic       chk_dato;
   } trans_t;

   typedef struct {
      logic        esc;
      logic        lee;
      logic [47:0] hin;
      int          lat;
      logic [7:0]  base;
      logic        perturba;
      logic [47:0] exp_hout;
      int          exp_ciclos;
   } vec_t;

   trans_t     cola[$];
   vec_t       tabla[4];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         lat_f  = 29;
   logic [7:0] base_dato   = 8'h10;
   logic       retener     = 1'b0;
   logic [7:0] retener_dir = 8'h00;
   int         m_cnt    = 0;
   logic       ini_prev = 1'b0;
   logic       mon_prev = 1'b0;

   task automatic chk(input string nombre, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
   endtask

   // control_salida model: final one cycle, lat_f cycles after iniciar rises.
   always @(negedge clk) begin
      if (!reset) begin
         fin_trans = 1'b0;
         m_cnt     = 0;
         ini_prev  = 1'b0;
      end else begin
         fin_trans = 1'b0;
         if (iniciar && !ini_prev) begin
            m_cnt = 1;
         end else if (m_cnt != 0) begin
            if (m_cnt == lat_f) begin
               m_cnt = 0;
               if (!(retener && (direccion == retener_dir))) begin
                  fin_trans = 1'b1;
                  dato_bus  = base_dato + direccion;
               end
            end else begin
               m_cnt++;
            end
         end
         ini_prev = iniciar;
      end
   end

   // Scoreboard: every transaction start must match the head of the queue.
   always @(negedge clk) begin
      trans_t e;
      if (reset && iniciar && !mon_prev) begin
         chk("trans_esperada", 48'(cola.size() != 0), 48'd1);
         if (cola.size() != 0) begin
            e = cola.pop_front();
            chk("escribe", 48'(escribe), 48'(e.escribe));
            chk("direccion", 48'(direccion), 48'(e.dir));
            if (e.chk_dato) chk("dato", 48'(dato), 48'(e.dato));
         end
      end
      mon_prev = reset ? iniciar : 1'b0;
   end

   task automatic encola(input logic es_esc, input logic [47:0] hin);
      trans_t t;
      if (es_esc) begin
         for (int j = 0; j < 6; j++) begin
            t.escribe = 1'b1; t.dir = 8'h21 + 8'(j); t.dato = hin[8*j +: 8]; t.chk_dato = 1'b1;
            cola.push_back(t);
         end
         t.escribe = 1'b1; t.dir = 8'hF1; t.dato = 8'h00; t.chk_dato = 1'b1;
         cola.push_back(t);
      end else begin
         t.escribe = 1'b1; t.dir = 8'hF0; t.dato = 8'h00; t.chk_dato = 1'b1;
         cola.push_back(t);
         for (int j = 0; j < 6; j++) begin
            t.escribe = 1'b0; t.dir = 8'h21 + 8'(j); t.dato = 8'h00; t.chk_dato = 1'b0;
            cola.push_back(t);
         end
      end
   endtask

   // Request on the next edge; returns at the negedge just after that edge.
   task automatic lanza(input logic esc, input logic lee, input logic [47:0] hin);
      @(negedge clk);
      escribir = esc; leer = lee; hora_in = hin;
      @(negedge clk);
      escribir = 1'b0; leer = 1'b0;
      chk("ocupado_ini", 48'(ocupado), 48'd1);
      chk("iniciar_ini", 48'(iniciar), 48'd1);
   endtask

   // Counts edges after the request until listo/error (or budget), optionally disturbing inputs.
   task automatic espera(input logic perturba, input logic [47:0] hin, output int ciclos);
      ciclos = 0;
      while ((ciclos < 400) && !listo && !error) begin
         @(posedge clk);
         ciclos++;
         @(negedge clk);
         if (perturba && (ciclos == 40)) hora_in = ~hin;
         if (perturba && (ciclos == 50)) leer = 1'b1;
         if (perturba && (ciclos == 51)) leer = 1'b0;
      end
   endtask

   task automatic corre(input vec_t v);
      int ciclos;
      lat_f = v.lat; base_dato = v.base;
      encola(v.esc, v.hin);
      lanza(v.esc, v.lee, v.hin);
      espera(v.perturba, v.hin, ciclos);
      chk("listo", 48'(listo), 48'd1);
      chk("error_no", 48'(error), 48'd0);
      chk("ciclos", 48'(ciclos), 48'(v.exp_ciclos));
      chk("ocupado_fin", 48'(ocupado), 48'd0);
      chk("hora_out", hora_out, v.exp_hout);
      @(negedge clk);
      chk("listo_pulso", 48'(listo), 48'd0);
      repeat (40) @(negedge clk);
      chk("cola_vacia", 48'(cola.size()), 48'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ciclos;
      vec_t v;
      reset = 1'b1; leer = 1'b0; escribir = 1'b0; hora_in = 48'h0;
      fin_trans = 1'b0; dato_bus = 8'h00;
      #1 reset = 1'b0;
      #2;
      chk("rst_iniciar", 48'(iniciar), 48'd0);
      chk("rst_escribe", 48'(escribe), 48'd0);
      chk("rst_direccion", 48'(direccion), 48'd0);
      chk("rst_dato", 48'(dato), 48'd0);
      chk("rst_hora_out", hora_out, 48'h0);
      chk("rst_ocupado", 48'(ocupado), 48'd0);
      chk("rst_listo", 48'(listo), 48'd0);
      chk("rst_error", 48'(error), 48'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      //            esc   lee   hora_in           F   base   pert  hora_out           cycles
      tabla[0] = '{1'b0, 1'b1, 48'h0,            29, 8'h10, 1'b0, 48'h363534333231, 218};
      tabla[1] = '{1'b1, 1'b0, 48'h160908123045, 29, 8'h10, 1'b1, 48'h363534333231, 218};
      tabla[2] = '{1'b1, 1'b1, 48'h0A0B0C0D0E0F, 29, 8'h10, 1'b0, 48'h363534333231, 218};
      tabla[3] = '{1'b0, 1'b1, 48'h0,             3, 8'h40, 1'b0, 48'h666564636261,  36};
      for (int k = 0; k < 4; k++) corre(tabla[k]);

      // Timeout on read transaction 3 (address 23): prior hora_out retained.
      lat_f = 29; base_dato = 8'h10; retener = 1'b1; retener_dir = 8'h23;
      encola(1'b0, 48'h0);
      repeat (3) void'(cola.pop_back());
      lanza(1'b0, 1'b1, 48'h0);
      espera(1'b0, 48'h0, ciclos);
      chk("to_error", 48'(error), 48'd1);
      chk("to_listo", 48'(listo), 48'd0);
      chk("to_ciclos", 48'(ciclos), 48'd153);
      chk("to_ocupado", 48'(ocupado), 48'd0);
      chk("to_iniciar", 48'(iniciar), 48'd0);
      chk("to_hora_out", hora_out, 48'h666564636261);
      @(negedge clk);
      chk("to_error_pulso", 48'(error), 48'd0);
      retener = 1'b0;
      repeat (40) @(negedge clk);
      chk("to_cola_vacia", 48'(cola.size()), 48'd0);

      // Reset during transaction 4 of a read: outputs clear with no clock edge.
      encola(1'b0, 48'h0);
      repeat (2) void'(cola.pop_back());
      lanza(1'b0, 1'b1, 48'h0);
      for (int c = 0; c < 134; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1 reset = 1'b0;
      #1;
      chk("mr_iniciar", 48'(iniciar), 48'd0);
      chk("mr_escribe", 48'(escribe), 48'd0);
      chk("mr_direccion", 48'(direccion), 48'd0);
      chk("mr_dato", 48'(dato), 48'd0);
      chk("mr_hora_out", hora_out, 48'h0);
      chk("mr_ocupado", 48'(ocupado), 48'd0);
      chk("mr_listo", 48'(listo), 48'd0);
      chk("mr_error", 48'(error), 48'd0);
      chk("mr_cola_vacia", 48'(cola.size()), 48'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      v = '{1'b0, 1'b1, 48'h0, 29, 8'h10, 1'b0, 48'h363534333231, 218};
      corre(v);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
